hamming_nibble_assembler: RTL and testbench
===========================================

# hamming_nibble_assembler

Downstream stage of the Hamming(8,4) SECDED decoder. Accepts decoded 4-bit nibbles with their error status, pairs consecutive nibbles into bytes, and buffers the bytes in a small FIFO behind a valid/ready output. It also keeps saturating corrected and uncorrectable error counters for the decode stream.

## Interface
Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; a power of two, ≥2
- CNT_W, 8, width of each error counter

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  nibble offered by decoder
- in_ready  out  1  nibble accepted when in_valid && in_ready
- in_nibble  in  4  decoded data nibble
- in_err  in  2  decoder error flag: 00 none, 01 single corrected, 10 double detected, 11 treated as double
- in_syndrome  in  3  decoder syndrome
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_byte  out  8  assembled byte, {high nibble, low nibble}
- out_err  out  1  either nibble of the head byte was uncorrectable
- clr_stats  in  1  synchronous clear of counters and last_syn
- corr_cnt  out  CNT_W  accepted nibbles with in_err==01
- uncorr_cnt  out  CNT_W  accepted nibbles with in_err[1]==1
- last_syn  out  3  syndrome of the most recent accepted nibble with in_err!=00
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Assembly FSM, two states:
  - LOW: an accepted nibble is stored as the low nibble, together with its bad flag (in_err[1]), and the FSM moves to HIGH.
  - HIGH: an accepted nibble forms the high nibble. The byte {in_nibble, stored low} is pushed, with out_err = stored bad | in_err[1], and the FSM returns to LOW.
- in_ready = (state==LOW) || !full. It does not depend on out_ready, so a full FIFO stalls the HIGH nibble even when a pop occurs in the same cycle.
- FIFO:
  - out_valid = !empty.
  - Pop on out_valid && out_ready.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - out_byte and out_err are 0 while the FIFO is empty.
- Counters:
  - Each counter increments by 1 per qualifying accepted nibble.
  - Each counter saturates at all-ones.
  - When clr_stats and an increment occur in the same cycle, clr_stats wins: the counter and last_syn go to 0.
- last_syn updates on every accepted nibble with in_err!=00, whatever the FSM state.
- Reset values:
  - FSM in LOW; any stored low nibble is discarded, including a half-assembled pair when reset arrives mid-operation.
  - FIFO empty.
  - out_valid=0, out_byte=0, out_err=0, fifo_level=0, corr_cnt=0, uncorr_cnt=0, last_syn=0.
  - in_ready=1 in the first cycle after reset.

## Timing
- If the high nibble is accepted at edge N and the FIFO was empty, out_valid=1 and out_byte are valid after edge N.
- The FIFO has no combinational path from in_* to out_*.
- Counters and last_syn reflect a nibble accepted at edge N immediately after edge N.
- Sustained throughput is one nibble per cycle, i.e. one byte every 2 cycles, while out_ready=1.
- When the FIFO is full, in_ready drops only while the FSM is in HIGH. The low nibble of the next pair is still accepted.

## Configuration
- Macro: HAMMING_DROP_BAD_EN
- When defined:
  - A pair with any uncorrectable nibble is not pushed.
  - The FSM still returns to LOW.
  - Counters still update.
  - out_err is tied to 0.
  - The bad-flag storage in the FIFO is not built.
- When undefined, all pairs are pushed and out_err flags the bad ones.

## Structure
- Package hamming_pkg holds:
  - the error-code localparams ERR_NONE=2'b00, ERR_CORR=2'b01, ERR_DUAL=2'b10
  - the assembly state typedef (ASM_LOW, ASM_HIGH)
- Sub-module hamming_byte_fifo: synchronous FIFO parameterised on width (9, or 8 with HAMMING_DROP_BAD_EN) and depth, with push, pop, full, empty and level.
- Counters and FSM live in the top of this block.

## Test plan
- Streaming pair: nibbles 4'h5 then 4'hA, both err 00, out_ready=1 → out_byte=8'hA5 and out_err=0 for one cycle; counters stay 0.
- Error tally: nibble 3 with err 01 and syndrome 3'b101, then nibble 7 with err 10 and syndrome 3'b011 → byte 8'h73, out_err=1 (undefined macro), corr_cnt=1, uncorr_cnt=1, last_syn=3'b011.
- Full FIFO with FIFO_DEPTH=4 and out_ready=0:
  - Send 5 pairs → fifo_level=4; the 9th nibble is accepted and in_ready=0 while in HIGH.
  - Raise out_ready → bytes drain in order, then the 5th byte completes.
- Saturation and clear:
  - Drive 300 err-01 nibbles with CNT_W=8 → corr_cnt=8'hFF.
  - clr_stats asserted together with an err-01 nibble → corr_cnt=0.
- Reset mid-pair: accept low nibble 4'hC, assert rst, then send 4'h1 and 4'h2 → out_byte=8'h21; no stale 4'hC appears.
- With HAMMING_DROP_BAD_EN: pair (err 10, err 00) then pair (4'h9, 4'h6, both err 00) → only 8'h69 is output; uncorr_cnt=1.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(8,4) nibble assembly stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: decoder error-code constants, the assembly FSM state type and
// a helper that classifies an error code as uncorrectable.
package hamming_pkg;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CORR = 2'b01;
    localparam logic [1:0] ERR_DUAL = 2'b10;

    typedef enum logic {
        ASM_LOW  = 1'b0,
        ASM_HIGH = 1'b1
    } asm_state_t;

    // Code 11 is treated as a double error, so any code with bit 1 set is bad.
    function automatic logic is_bad(input logic [1:0] err);
        return (err & ERR_DUAL) != ERR_NONE;
    endfunction

endpackage

// File: rtl/hamming_byte_fifo.sv
// Synchronous FIFO holding assembled bytes (plus optional bad flag).
// Latency: a push is visible at the head one cycle later; no comb path in->out.
// Backpressure: push is ignored while full, pop is ignored while empty.
//
// Ports: clk, rst (sync, active high); push/push_dat write side;
//        pop/pop_dat read side (pop_dat forced to 0 when empty);
//        full, empty, level (occupancy, 0..DEPTH).
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module hamming_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (!do_push && do_pop)
                level <= level - 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/hamming_nibble_assembler.sv
// Pairs decoded nibbles into bytes, queues them, and tallies decode errors.
// Latency: high nibble accepted at edge N -> byte at FIFO head after edge N.
// Backpressure: in_ready low only in HIGH with FIFO full; independent of out_ready.
//
// Ports: clk, rst (sync, active high);
//        in_valid/in_ready/in_nibble/in_err/in_syndrome  nibble input;
//        out_valid/out_ready/out_byte/out_err            byte output;
//        clr_stats, corr_cnt, uncorr_cnt, last_syn, fifo_level  status.
// Build option HAMMING_DROP_BAD_EN: pairs with an uncorrectable nibble are
// discarded instead of queued, out_err is tied low and the FIFO is 8 bits wide.
module hamming_nibble_assembler
    import hamming_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_nibble,
    input  logic [1:0]                    in_err,
    input  logic [2:0]                    in_syndrome,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
    output logic                          out_err,
    input  logic                          clr_stats,
    output logic [CNT_W-1:0]              corr_cnt,
    output logic [CNT_W-1:0]              uncorr_cnt,
    output logic [2:0]                    last_syn,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

`ifdef HAMMING_DROP_BAD_EN
    localparam int FW = 8;
`else
    localparam int FW = 9;
`endif

    asm_state_t  state;
    logic [3:0]  low_nib;
    logic        low_bad;
    logic        accept;
    logic        pair_bad;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [FW-1:0] push_dat;
    logic [FW-1:0] pop_dat;

    assign in_ready = (state == ASM_LOW) || !full;
    assign accept   = in_valid && in_ready;
    assign pair_bad = low_bad | is_bad(in_err);
    assign pop      = out_valid && out_ready;
    assign out_valid = !empty;

`ifdef HAMMING_DROP_BAD_EN
    assign push     = accept && (state == ASM_HIGH) && !pair_bad;
    assign push_dat = {in_nibble, low_nib};
    assign out_byte = pop_dat;
    assign out_err  = 1'b0;
`else
    assign push     = accept && (state == ASM_HIGH);
    assign push_dat = {pair_bad, in_nibble, low_nib};
    assign out_byte = pop_dat[7:0];
    assign out_err  = pop_dat[8];
`endif

    // Assembly FSM: first nibble of a pair is held, second completes the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ASM_LOW;
            low_nib <= '0;
            low_bad <= 1'b0;
        end else if (accept) begin
            if (state == ASM_LOW) begin
                low_nib <= in_nibble;
                low_bad <= is_bad(in_err);
                state   <= ASM_HIGH;
            end else begin
                state   <= ASM_LOW;
            end
        end
    end

    // Saturating error statistics; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            last_syn   <= '0;
        end else if (accept) begin
            if (in_err == ERR_CORR && corr_cnt != '1)
                corr_cnt <= corr_cnt + 1'b1;
            if (is_bad(in_err) && uncorr_cnt != '1)
                uncorr_cnt <= uncorr_cnt + 1'b1;
            if (in_err != ERR_NONE)
                last_syn <= in_syndrome;
        end
    end

    hamming_byte_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_hamming_nibble_assembler.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hamming_nibble_assembler;

    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_nibble;
    logic [1:0]    in_err;
    logic [2:0]    in_syndrome;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_byte;
    logic          out_err;
    logic          clr_stats;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;
    logic [2:0]    last_syn;
    logic [LW-1:0] fifo_level;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hamming_nibble_assembler #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_nibble(in_nibble),
        .in_err(in_err), .in_syndrome(in_syndrome),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_err(out_err), .clr_stats(clr_stats),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .last_syn(last_syn),
        .fifo_level(fifo_level)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] b;
        logic       e;
    } ent_t;

    ent_t q[$];
    int   nib_count;      // nibbles accepted since reset; odd means a low nibble is held
    logic [3:0] held_nib;
    logic       held_bad;
    int   m_corr, m_uncorr;
    logic [2:0] m_syn;

    function automatic bit model_ready();
        return (nib_count % 2 == 0) || (q.size() < DEPTH);
    endfunction

    always @(posedge clk) begin
        bit   acc;
        bit   bad;
        ent_t e;
        if (rst) begin
            q.delete();
            nib_count = 0;
            held_nib  = 4'h0;
            held_bad  = 1'b0;
            m_corr    = 0;
            m_uncorr  = 0;
            m_syn     = 3'b000;
        end else begin
            acc = in_valid && model_ready();
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                if (nib_count % 2 == 1) begin
                    bad = held_bad | in_err[1];
                    e.b = {in_nibble, held_nib};
`ifdef HAMMING_DROP_BAD_EN
                    e.e = 1'b0;
                    if (!bad) q.push_back(e);
`else
                    e.e = bad;
                    q.push_back(e);
`endif
                end else begin
                    held_nib = in_nibble;
                    held_bad = in_err[1];
                end
                nib_count++;
                if (in_err == 2'b01) m_corr   = (m_corr   < 255) ? m_corr + 1   : 255;
                if (in_err[1])       m_uncorr = (m_uncorr < 255) ? m_uncorr + 1 : 255;
                if (in_err != 2'b00) m_syn = in_syndrome;
            end
            if (clr_stats) begin
                m_corr = 0; m_uncorr = 0; m_syn = 3'b000;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("in_ready",   32'(in_ready),   32'(model_ready()));
            chk("out_valid",  32'(out_valid),  32'(q.size() > 0));
            chk("out_byte",   32'(out_byte),   (q.size() > 0) ? 32'(q[0].b) : 32'h0);
            chk("out_err",    32'(out_err),    (q.size() > 0) ? 32'(q[0].e) : 32'h0);
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
            chk("corr_cnt",   32'(corr_cnt),   32'(m_corr));
            chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
            chk("last_syn",   32'(last_syn),   32'(m_syn));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [3:0] nib, input logic [1:0] err, input logic [2:0] syn);
        int n = 0;
        in_valid = 1'b1; in_nibble = nib; in_err = err; in_syndrome = syn;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL send_timeout: in_ready stayed 0, required 1");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_nibble = '0; in_err = '0; in_syndrome = '0;
        out_ready = 1'b0; clr_stats = 1'b0;
        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_byte", 32'(out_byte), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_corr", 32'(corr_cnt), 32'h0);
        @(posedge clk); #1;

        // streaming pair
        out_ready = 1'b1;
        send(4'h5, 2'b00, 3'b000);
        send(4'hA, 2'b00, 3'b000);
        @(negedge clk);
        chk("pair_byte", 32'(out_byte), 32'hA5);
        chk("pair_err", 32'(out_err), 32'h0);
        chk("pair_valid", 32'(out_valid), 32'h1);
        chk("pair_corr", 32'(corr_cnt), 32'h0);
        @(negedge clk);
        chk("pair_popped", 32'(out_valid), 32'h0);
        @(posedge clk); #1;

        // error tally
        out_ready = 1'b0;
        send(4'h3, 2'b01, 3'b101);
        send(4'h7, 2'b10, 3'b011);
        @(negedge clk);
`ifdef HAMMING_DROP_BAD_EN
        chk("tally_dropped", 32'(out_valid), 32'h0);
`else
        chk("tally_byte", 32'(out_byte), 32'h73);
        chk("tally_err", 32'(out_err), 32'h1);
`endif
        chk("tally_corr", 32'(corr_cnt), 32'h1);
        chk("tally_uncorr", 32'(uncorr_cnt), 32'h1);
        chk("tally_syn", 32'(last_syn), 32'h3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(3);

        // full FIFO: 4 pairs fill it, 9th nibble accepted, 10th stalls
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(4'(i), 2'b00, 3'b000);
            send(4'(i + 8), 2'b00, 3'b000);
        end
        send(4'h4, 2'b00, 3'b000);
        @(negedge clk);
        chk("full_level", 32'(fifo_level), 32'h4);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("full_head", 32'(out_byte), 32'h80);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'hC, 2'b00, 3'b000);
        idle(8);
        @(negedge clk);
        chk("drain_level", 32'(fifo_level), 32'h0);
        @(posedge clk); #1;

        // saturation and clear
        pulse_clr();
        for (int i = 0; i < 300; i++) send(4'($urandom_range(0, 15)), 2'b01, 3'b001);
        @(negedge clk);
        chk("sat_corr", 32'(corr_cnt), 32'hFF);
        @(posedge clk); #1;
        clr_stats = 1'b1;
        send(4'h1, 2'b01, 3'b110);
        clr_stats = 1'b0;
        @(negedge clk);
        chk("clr_corr", 32'(corr_cnt), 32'h0);
        chk("clr_syn", 32'(last_syn), 32'h0);
        @(posedge clk); #1;
        send(4'h2, 2'b00, 3'b000);
        idle(3);

        // reset mid-pair
        out_ready = 1'b0;
        send(4'hC, 2'b00, 3'b000);
        rst = 1'b1; idle(1); rst = 1'b0;
        send(4'h1, 2'b00, 3'b000);
        send(4'h2, 2'b00, 3'b000);
        @(negedge clk);
        chk("midrst_byte", 32'(out_byte), 32'h21);
        chk("midrst_level", 32'(fifo_level), 32'h1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(3);

`ifdef HAMMING_DROP_BAD_EN
        // bad pair discarded, good pair kept
        out_ready = 1'b0;
        pulse_clr();
        send(4'h1, 2'b10, 3'b001);
        send(4'h4, 2'b00, 3'b000);
        send(4'h9, 2'b00, 3'b000);
        send(4'h6, 2'b00, 3'b000);
        @(negedge clk);
        chk("drop_level", 32'(fifo_level), 32'h1);
        chk("drop_byte", 32'(out_byte), 32'h69);
        chk("drop_uncorr", 32'(uncorr_cnt), 32'h1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(3);
`endif

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_nibble   = 4'($urandom_range(0, 15));
            in_err      = 2'($urandom_range(0, 3));
            in_syndrome = 3'($urandom_range(0, 7));
            if (c < 1000)
                out_ready = ($urandom_range(0, 3) == 0);
            else
                out_ready = ($urandom_range(0, 3) != 0);
            clr_stats   = ($urandom_range(0, 63) == 0);
            idle(1);
        end
        in_valid = 1'b0; clr_stats = 1'b0; out_ready = 1'b1;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
